imm_gen_pipe: RTL and testbench

//  Pipelined, parametrised RISC-V immediate generator between IF/ID and ID/EX.

---
 rtl/imm_gen_pipe.sv | 164 ++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator feeding a 2-entry skid buffer with valid/ready handshakes.
// Counts accepted words with an unrecognised opcode in a saturating counter.
//
// state | meaning
// EMPTY | no entries held, head outputs invalid
// ONE   | head entry valid, second slot free
// FULL  | both entries valid, input stalled
module imm_gen_pipe #(
  parameter int XLEN        = 32,
  parameter bit BJ_BYTE_OFS = 1'b1,
  parameter int CNT_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      instr_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  imm_o,
  output logic [2:0]       fmt_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_SHAMT = 3'd6;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } entry_t;

  state_t     state_q, state_d;
  entry_t     dec, ent0_q, ent1_q;
  logic       push, pop;
  logic [6:0] opc;
  logic [2:0] funct3;

  assign opc    = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  always_comb begin
    dec.imm = '0;
    dec.fmt = FMT_NONE;
    dec.ill = 1'b0;
    case (opc)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        if (opc == 7'b0010011 && (funct3 == 3'b001 || funct3 == 3'b101)) begin
          dec.fmt = FMT_SHAMT;
          if (XLEN == 64) dec.imm = XLEN'(instr_i[25:20]);
          else            dec.imm = XLEN'(instr_i[24:20]);
        end else begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(instr_i[31:20]));
        end
      end
      7'b0100011: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
      end
      7'b1100011: begin
        dec.fmt = FMT_B;
        if (BJ_BYTE_OFS)
          dec.imm = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0}));
        else
          dec.imm = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8]}));
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = FMT_U;
        dec.imm = XLEN'($signed({instr_i[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec.fmt = FMT_J;
        if (BJ_BYTE_OFS)
          dec.imm = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0}));
        else
          dec.imm = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21]}));
      end
      default: dec.ill = 1'b1;
    endcase
  end

  // ready_o depends only on the state register, so push never sees ready_i combinationally
  assign push = valid_i & ready_o & ~flush_i;
  assign pop  = valid_o & ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (push) state_d = ONE;
        ONE: begin
          if (push && !pop)      state_d = FULL;
          else if (pop && !push) state_d = EMPTY;
        end
        FULL:    if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_comb begin
    valid_o = 1'b0;
    ready_o = 1'b1;
    case (state_q)
      ONE:  valid_o = 1'b1;
      FULL: begin
        valid_o = 1'b1;
        ready_o = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
    end else if (!flush_i) begin
      case (state_q)
        EMPTY: if (push) ent0_q <= dec;
        ONE: begin
          if (push && pop) ent0_q <= dec;
          else if (push)   ent1_q <= dec;
        end
        FULL:  if (pop) ent0_q <= ent1_q;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                                     illegal_cnt_o <= '0;
    else if (push && dec.ill && illegal_cnt_o != '1) illegal_cnt_o <= illegal_cnt_o + 1'b1;
  end

  assign imm_o     = ent0_q.imm;
  assign fmt_o     = ent0_q.fmt;
  assign illegal_o = ent0_q.ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: two parameterisations share one stimulus stream and are
// compared each cycle against a queue-based reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, valid_in, ready_in;
  logic [31:0] instr;

  logic        rdy_a, vld_a, ill_a;
  logic [31:0] imm_a;
  logic [2:0]  fmt_a;
  logic [7:0]  cnt_a_dut;

  logic        rdy_b, vld_b, ill_b;
  logic [63:0] imm_b;
  logic [2:0]  fmt_b;
  logic [1:0]  cnt_b_dut;

  imm_gen_pipe #(.XLEN(32), .BJ_BYTE_OFS(1'b1), .CNT_W(8)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .valid_i(valid_in), .ready_o(rdy_a),
    .instr_i(instr), .valid_o(vld_a), .ready_i(ready_in), .imm_o(imm_a), .fmt_o(fmt_a),
    .illegal_o(ill_a), .illegal_cnt_o(cnt_a_dut));

  imm_gen_pipe #(.XLEN(64), .BJ_BYTE_OFS(1'b0), .CNT_W(2)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .valid_i(valid_in), .ready_o(rdy_b),
    .instr_i(instr), .valid_o(vld_b), .ready_i(ready_in), .imm_o(imm_b), .fmt_o(fmt_b),
    .illegal_o(ill_b), .illegal_cnt_o(cnt_b_dut));

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] imm;
    int          fmt;
  } ent_t;

  ent_t qa[$], qb[$];
  int   cnt_a, cnt_b;
  int   n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Immediate value from the ISA field definitions, as a signed integer masked to xlen.
  function automatic logic [63:0] model_imm(input logic [31:0] w, input int xlen, input bit bj,
                                            output int fmt);
    longint v = 0;
    fmt = 0;
    case (w[6:0])
      7'h13, 7'h03, 7'h67: begin
        if (w[6:0] == 7'h13 && (w[14:12] == 3'd1 || w[14:12] == 3'd5)) begin
          fmt = 6;
          v = (xlen == 64) ? longint'(w[25:20]) : longint'(w[24:20]);
        end else begin
          fmt = 1;
          v = longint'(w[31:20]);
          if (v >= 2048) v -= 4096;
        end
      end
      7'h23: begin
        fmt = 2;
        v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        if (v >= 2048) v -= 4096;
      end
      7'h63: begin
        fmt = 3;
        v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048 + longint'(w[30:25]) * 32
            + longint'(w[11:8]) * 2;
        if (v >= 4096) v -= 8192;
        if (!bj) v = v / 2;
      end
      7'h37, 7'h17: begin
        fmt = 4;
        v = longint'(w[31:12]) * 4096;
        if (w[31]) v -= 64'sd4294967296;
      end
      7'h6F: begin
        fmt = 5;
        v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 + longint'(w[20]) * 2048
            + longint'(w[30:21]) * 2;
        if (v >= 1048576) v -= 2097152;
        if (!bj) v = v / 2;
      end
      default: v = 0;
    endcase
    model_imm = (xlen == 32) ? {32'b0, v[31:0]} : v;
  endfunction

  task automatic check_outputs();
    chk("a_valid", 64'(vld_a), 64'(qa.size() != 0));
    chk("a_ready", 64'(rdy_a), 64'(qa.size() < 2));
    chk("a_cnt", 64'(cnt_a_dut), 64'(cnt_a));
    if (qa.size() != 0) begin
      chk("a_imm", {32'b0, imm_a}, qa[0].imm);
      chk("a_fmt", 64'(fmt_a), 64'(qa[0].fmt));
      chk("a_ill", 64'(ill_a), 64'(qa[0].fmt == 0));
    end
    chk("b_valid", 64'(vld_b), 64'(qb.size() != 0));
    chk("b_ready", 64'(rdy_b), 64'(qb.size() < 2));
    chk("b_cnt", 64'(cnt_b_dut), 64'(cnt_b));
    if (qb.size() != 0) begin
      chk("b_imm", imm_b, qb[0].imm);
      chk("b_fmt", 64'(fmt_b), 64'(qb[0].fmt));
      chk("b_ill", 64'(ill_b), 64'(qb[0].fmt == 0));
    end
  endtask

  task automatic model_update();
    bit   push, pop;
    ent_t ea, eb;
    push = valid_in && qa.size() < 2 && !flush;
    pop  = qa.size() != 0 && ready_in;
    if (flush) begin
      qa.delete();
      qb.delete();
    end else begin
      if (pop) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (push) begin
        ea.imm = model_imm(instr, 32, 1'b1, ea.fmt);
        eb.imm = model_imm(instr, 64, 1'b0, eb.fmt);
        qa.push_back(ea);
        qb.push_back(eb);
        if (ea.fmt == 0) begin
          if (cnt_a < 255) cnt_a++;
          if (cnt_b < 3)   cnt_b++;
        end
      end
    end
  endtask

  task automatic step(input bit v, input logic [31:0] w, input bit r, input bit f);
    @(negedge clk);
    check_outputs();
    valid_in = v;
    instr    = w;
    ready_in = r;
    flush    = f;
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_a_valid", 64'(vld_a), 64'd0);
    chk("rst_a_ready", 64'(rdy_a), 64'd1);
    chk("rst_a_imm", {32'b0, imm_a}, 64'd0);
    chk("rst_a_fmt", 64'(fmt_a), 64'd0);
    chk("rst_a_ill", 64'(ill_a), 64'd0);
    chk("rst_a_cnt", 64'(cnt_a_dut), 64'd0);
    chk("rst_b_valid", 64'(vld_b), 64'd0);
    chk("rst_b_imm", imm_b, 64'd0);
    chk("rst_b_cnt", 64'(cnt_b_dut), 64'd0);
    qa.delete();
    qb.delete();
    cnt_a = 0;
    cnt_b = 0;
    valid_in = 1'b1;
    instr    = 32'hFFF00093;
    @(posedge clk);
    #1;
    chk("rst_ignores_valid", 64'(vld_a), 64'd0);
    @(negedge clk);
    valid_in = 1'b0;
    rst_n    = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0]  opcs [9];
    opcs = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F};
    w = $urandom;
    if ($urandom_range(0, 9) != 0) w[6:0] = opcs[$urandom_range(0, 8)];
    return w;
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b0; instr = '0;
    cnt_a = 0; cnt_b = 0;
    do_reset();

    step(1, 32'hFFF00093, 0, 0);
    chk("addi_imm", {32'b0, imm_a}, 64'h0000_0000_FFFF_FFFF);
    chk("addi_fmt", 64'(fmt_a), 64'd1);
    chk("addi_imm64", imm_b, 64'hFFFF_FFFF_FFFF_FFFF);
    step(0, 32'h0, 1, 0);

    step(1, 32'h0020A423, 1, 0);
    chk("sw_imm", {32'b0, imm_a}, 64'd8);
    chk("sw_fmt", 64'(fmt_a), 64'd2);
    step(1, 32'h00509093, 1, 0);
    chk("slli_imm", {32'b0, imm_a}, 64'd5);
    chk("slli_fmt", 64'(fmt_a), 64'd6);

    step(1, 32'hFE000EE3, 1, 0);
    chk("beq_imm", {32'b0, imm_a}, 64'h0000_0000_FFFF_FFFC);
    chk("beq_imm_half", imm_b, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("beq_fmt", 64'(fmt_b), 64'd3);

    step(1, 32'h800000B7, 1, 0);
    chk("lui_imm64", imm_b, 64'hFFFF_FFFF_8000_0000);
    chk("lui_fmt", 64'(fmt_b), 64'd4);
    step(0, 32'h0, 1, 0);

    step(1, 32'h00100093, 0, 0);
    step(1, 32'h00200093, 0, 0);
    chk("full_ready", 64'(rdy_a), 64'd0);
    step(1, 32'h00300093, 0, 0);
    chk("stall_head", {32'b0, imm_a}, 64'd1);
    step(1, 32'h00300093, 1, 0);
    chk("order_b", {32'b0, imm_a}, 64'd2);
    step(1, 32'h00300093, 1, 0);
    chk("order_c", {32'b0, imm_a}, 64'd3);
    step(0, 32'h0, 1, 0);

    step(1, 32'h00100093, 0, 0);
    step(1, 32'h00200093, 0, 0);
    step(1, 32'h0000007F, 0, 1);
    chk("flush_valid", 64'(vld_a), 64'd0);
    chk("flush_ready", 64'(rdy_a), 64'd1);
    chk("flush_nocount", 64'(cnt_b_dut), 64'd0);
    for (int i = 0; i < 5; i++) step(1, 32'h0000007F, 1, 0);
    chk("cnt_sat", 64'(cnt_b_dut), 64'd3);
    chk("cnt_a5", 64'(cnt_a_dut), 64'd5);
    step(0, 32'h0, 1, 0);

    step(1, 32'h0020A423, 0, 0);
    step(1, 32'h00509093, 0, 0);
    do_reset();

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
           $urandom_range(0, 15) == 0);
    do_reset();
    for (int i = 0; i < 100; i++)
      step($urandom_range(0, 1) != 0, rand_instr(), $urandom_range(0, 3) == 0, 1'b0);
    step(0, 32'h0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
